// File: rtl/div5_pkg.sv
// Shared types and the radix-8 divide-by-5 digit function used by div5_seq_radix8.
package div5_pkg;

    localparam int DIGIT_W = 3;
    localparam int REM_W   = 3;
    localparam int DIVISOR = 5;
    localparam int V_W     = REM_W + DIGIT_W;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } div5_state_t;

    function automatic int steps(input int w);
        return (w + 2) / 3;
    endfunction

    // Remainders above DIVISOR-1 can never occur; they map to zero so the LUT is fully specified.
    function automatic logic [V_W-1:0] div5_digit(input logic [REM_W-1:0] rem,
                                                  input logic [DIGIT_W-1:0] d);
        logic [V_W-1:0] v;
        v = {rem, d};
        if (rem > REM_W'(DIVISOR - 1)) begin
            return '0;
        end
        return {DIGIT_W'(v / V_W'(DIVISOR)), REM_W'(v % V_W'(DIVISOR))};
    endfunction

endpackage

// File: rtl/div5_digit_lut.sv
// Combinational 6-in/6-out digit step: {rem,d} -> {q,r} with 8*rem+d = 5*q + r.
module div5_digit_lut
    import div5_pkg::*;
(
    input  logic [V_W-1:0] idx,
    output logic [V_W-1:0] val
);

    assign val = div5_digit(idx[V_W-1 -: REM_W], idx[DIGIT_W-1:0]);

endmodule

// File: rtl/div5_seq_radix8.sv
// Iterative unsigned divide-by-5, one radix-8 digit per clock, MSB first.
// Optional remainder output enabled by defining DIV5_REM_OUT_EN.
module div5_seq_radix8
    import div5_pkg::*;
#(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_quot
`ifdef DIV5_REM_OUT_EN
    ,
    output logic [REM_W-1:0] out_rem
`endif
);

    localparam int STEPS = steps(W);
    localparam int PW    = DIGIT_W * STEPS;
    localparam int CNT_W = $clog2(STEPS + 1);

    div5_state_t        state;
    div5_state_t        state_nxt;
    logic [PW-1:0]      shreg;
    logic [PW-1:0]      quot;
    logic [REM_W-1:0]   rem;
    logic [CNT_W-1:0]   cnt;
    logic [DIGIT_W-1:0] d;
    logic [DIGIT_W-1:0] qdigit;
    logic [REM_W-1:0]   rem_nxt;
    logic [V_W-1:0]     lut_val;
    logic               last_step;
    logic               accept;

    assign d         = shreg[PW-1 -: DIGIT_W];
    assign last_step = (cnt == CNT_W'(STEPS - 1));
    assign accept    = in_valid && in_ready;

    div5_digit_lut u_lut (
        .idx({rem, d}),
        .val(lut_val)
    );

    assign qdigit  = lut_val[V_W-1 -: DIGIT_W];
    assign rem_nxt = lut_val[REM_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (last_step) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Digit recurrence: consume the dividend MSB-first, shift quotient digits in at the bottom.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg <= '0;
            quot  <= '0;
            rem   <= '0;
            cnt   <= '0;
        end else if (accept) begin
            shreg <= PW'(in_data);
            quot  <= '0;
            rem   <= '0;
            cnt   <= '0;
        end else if (state == RUN) begin
            shreg <= shreg << DIGIT_W;
            quot  <= {quot[PW-DIGIT_W-1:0], qdigit};
            rem   <= rem_nxt;
            cnt   <= cnt + 1'b1;
        end
    end

    // Padding digits are leading zeros of the dividend, so quot[PW-1:W] is always zero.
    assign out_quot = quot[W-1:0];
`ifdef DIV5_REM_OUT_EN
    assign out_rem = rem;
`endif

    a_rem_range : assert property (@(posedge clk) disable iff (!rst_n) rem <= REM_W'(DIVISOR - 1));

    generate
        if (PW > W) begin : g_pad_zero
            a_quot_pad : assert property (@(posedge clk) disable iff (!rst_n) quot[PW-1:W] == '0);
        end
    endgenerate

endmodule

// File: tb/tb_div5_seq_radix8.sv
// Scoreboard bench for div5_seq_radix8 (W=64); remainder checks follow DIV5_REM_OUT_EN.
module tb_div5_seq_radix8;

    localparam int W      = 64;
    localparam int STEPS  = 22;
    localparam int N_RAND = 1500;

    typedef struct {
        logic [63:0] q;
        logic [2:0]  r;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_quot;
`ifdef DIV5_REM_OUT_EN
    logic [2:0]   out_rem;
`endif

    exp_t sb[$];
    int   n_checks  = 0;
    int   n_errors  = 0;
    int   n_out     = 0;
    int   cyc       = 0;
    int   acc_cyc   = 0;
    logic prev_ov   = 1'b0;
    logic rand_mode = 1'b0;

    div5_seq_radix8 #(.W(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
`ifdef DIV5_REM_OUT_EN
        .out_rem  (out_rem),
`endif
        .out_quot (out_quot)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s obs=%h exp=%h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    // Monitor: inputs/outputs are stable at the falling edge; handshakes seen here fire on the next rising edge.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (in_valid && in_ready) begin
                e.q = in_data / 64'd5;
                e.r = 3'(in_data % 64'd5);
                sb.push_back(e);
                acc_cyc = cyc;
            end
            if (out_valid && !prev_ov) begin
                check_val("latency", 64'(cyc - acc_cyc - 1), 64'(STEPS));
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check_val("sb_underflow", 64'(sb.size()), 64'd1);
                end else begin
                    e = sb.pop_front();
                    check_val("quot", out_quot, e.q);
`ifdef DIV5_REM_OUT_EN
                    check_val("rem", 64'(out_rem), 64'(e.r));
`endif
                end
                n_out++;
            end
            prev_ov = out_valid;
        end else begin
            prev_ov = 1'b0;
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_mode) out_ready = ($urandom_range(0, 3) != 0);
    end

    // Called at posedge+1; returns at posedge+1 after the accept edge.
    task automatic send(input logic [63:0] x);
        int t = 0;
        while (!in_ready && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (!in_ready) check_val("send_timeout", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_data  = x;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out();
        int start = n_out;
        int t = 0;
        while (n_out == start && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (n_out == start) check_val("out_timeout", 64'(n_out - start), 64'd1);
    endtask

    initial begin
        logic [63:0] x;
        logic        stale;
        int          t;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_in_ready", 64'(in_ready), 64'd1);
        check_val("rst_out_valid", 64'(out_valid), 64'd0);
        check_val("rst_out_quot", out_quot, 64'd0);
`ifdef DIV5_REM_OUT_EN
        check_val("rst_out_rem", 64'(out_rem), 64'd0);
`endif
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;

        send(64'd0);                    wait_out();
        send(64'hFFFF_FFFF_FFFF_FFFF);  wait_out();
        send(64'd7);                    wait_out();
        send(64'd1234567);              wait_out();
        send(64'd4);                    wait_out();
        send(64'h8000_0000_0000_0000);  wait_out();

        // Backpressure in DONE with in_valid pulses that must be ignored.
        out_ready = 1'b0;
        x = 64'h0123_4567_89AB_CDEF;
        send(x);
        t = 0;
        while (!out_valid && t < 60) begin
            @(negedge clk);
            t++;
        end
        check_val("stall_reach_done", 64'(out_valid), 64'd1);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            in_valid = k[0];
            in_data  = {$urandom, $urandom};
            @(negedge clk);
            check_val("stall_out_valid", 64'(out_valid), 64'd1);
            check_val("stall_in_ready", 64'(in_ready), 64'd0);
            check_val("stall_quot", out_quot, x / 64'd5);
        end
        // Handoff and a new dividend offered together: only the handoff happens this edge.
        @(posedge clk);
        #1;
        in_valid  = 1'b1;
        in_data   = 64'd1000;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check_val("handoff_idle_ready", 64'(in_ready), 64'd1);
        check_val("handoff_idle_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_val("next_accepted", 64'(in_ready), 64'd0);
        wait_out();

        // Reset at RUN step 10: result discarded, no stale out_valid afterwards.
        send(64'd999_999_999);
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        sb.delete();
        @(negedge clk);
        check_val("midrun_in_ready", 64'(in_ready), 64'd1);
        check_val("midrun_out_valid", 64'(out_valid), 64'd0);
        check_val("midrun_out_quot", out_quot, 64'd0);
`ifdef DIV5_REM_OUT_EN
        check_val("midrun_out_rem", 64'(out_rem), 64'd0);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        stale = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (out_valid || !in_ready) stale = 1'b1;
        end
        check_val("no_stale_valid", 64'(stale), 64'd0);
        @(posedge clk);
        #1;
        send(64'd25);
        wait_out();

        // Random back-to-back traffic with consumer stalls.
        rand_mode = 1'b1;
        for (int i = 0; i < N_RAND; i++) begin
            if (i % 97 == 0)      x = 64'hFFFF_FFFF_FFFF_FFFF;
            else if (i % 89 == 0) x = 64'd0;
            else if (i % 7 == 0)  x = 64'($urandom_range(0, 100));
            else                  x = {$urandom, $urandom};
            send(x);
        end
        t = 0;
        while (sb.size() != 0 && t < 300) begin
            @(posedge clk);
            t++;
        end
        rand_mode = 1'b0;
        check_val("drain", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
